// File: rtl/react_pkg.sv
// Shared types and constants for the reaction-timer measurement core.
// Holds the FSM state encoding, display codes and the delay LFSR step.
package react_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT,
    GO,
    SHOW,
    EARLY
  } state_t;

  localparam logic [15:0] DAT_EARLY = 16'hEEEE;
  localparam logic [15:0] DAT_MAX   = 16'h9999;

  // Fibonacci taps 16,14,13,11 -> bits 15,13,12,10
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic logic [15:0] lfsr_next(input logic [15:0] v);
    return {v[14:0], ^(v & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/react_bcd_cnt.sv
// Four-digit BCD up-counter with synchronous clear; one step per enabled cycle.
// Holds at 9999 when enabled at the top; at_max flags that value combinationally.
module react_bcd_cnt
  import react_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        i_clr,
  input  logic        i_en,
  output logic [15:0] o_dat,
  output logic        o_at_max
);

  logic [15:0] r_dat;
  logic [15:0] w_inc;
  logic        w_carry;

  assign o_dat    = r_dat;
  assign o_at_max = (r_dat == DAT_MAX);

  // Ripple the carry from units upward: a 9 wraps to 0, anything else ends the carry.
  always_comb begin
    w_inc   = r_dat;
    w_carry = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (w_carry) begin
        if (r_dat[4*i +: 4] == 4'd9) begin
          w_inc[4*i +: 4] = 4'd0;
        end else begin
          w_inc[4*i +: 4] = r_dat[4*i +: 4] + 4'd1;
          w_carry         = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_dat <= 16'h0000;
    end else if (i_clr) begin
      r_dat <= 16'h0000;
    end else if (i_en && !o_at_max) begin
      r_dat <= w_inc;
    end
  end

endmodule

// File: rtl/react_timer.sv
// Reaction tester core: random delay, stimulus LED, then BCD millisecond count to react press.
// Button effects land 3 clk after the pin is sampled; held buttons fire once.
module react_timer
  import react_pkg::*;
#(
  parameter int          TICK_DIV   = 100000,
  parameter int          MIN_DLY_MS = 1000,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        btn_start,
  input  logic        btn_react,
  output logic        led_go,
  output logic [15:0] dat,
  output logic        busy,
  output logic        early,
  output logic        timeout
);

  localparam int            PW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] TICK_LAST = PW'(TICK_DIV - 1);

  state_t        r_state;
  state_t        w_state_nxt;
  logic [2:0]    r_start_sync;
  logic [2:0]    r_react_sync;
  logic          r_start_pulse;
  logic          r_react_pulse;
  logic [PW-1:0] r_presc;
  logic [15:0]   r_lfsr;
  logic [15:0]   r_dly;
  logic          r_led_go;
  logic          r_busy;
  logic          r_early;
  logic          r_timeout;

  logic          w_tick;
  logic          w_cnt_clr;
  logic          w_cnt_en;
  logic          w_dly_load;
  logic          w_dly_dec;
  logic          w_set_timeout;
  logic          w_at_max;
  logic [15:0]   w_bcd;

  assign w_tick  = (r_presc == TICK_LAST);
  assign led_go  = r_led_go;
  assign busy    = r_busy;
  assign early   = r_early;
  assign timeout = r_timeout;
  assign dat     = r_early ? DAT_EARLY : w_bcd;

  // Two sync stages plus a registered edge pulse: pin sampled at edge n acts at edge n+3.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_start_sync  <= 3'b000;
      r_react_sync  <= 3'b000;
      r_start_pulse <= 1'b0;
      r_react_pulse <= 1'b0;
    end else begin
      r_start_sync  <= {r_start_sync[1:0], btn_start};
      r_react_sync  <= {r_react_sync[1:0], btn_react};
      r_start_pulse <= r_start_sync[1] & ~r_start_sync[2];
      r_react_pulse <= r_react_sync[1] & ~r_react_sync[2];
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_clr     = 1'b0;
    w_cnt_en      = 1'b0;
    w_dly_load    = 1'b0;
    w_dly_dec     = 1'b0;
    w_set_timeout = 1'b0;
    case (r_state)
      IDLE, SHOW, EARLY: begin
        if (r_start_pulse) begin
          w_state_nxt = WAIT;
          w_cnt_clr   = 1'b1;
          w_dly_load  = 1'b1;
        end
      end
      WAIT: begin
        if (r_react_pulse) begin
          w_state_nxt = EARLY;
        end else if (w_tick) begin
          if (r_dly <= 16'd1) w_state_nxt = GO;
          else                w_dly_dec   = 1'b1;
        end
      end
      GO: begin
        // React wins over a same-cycle tick, so the last increment is dropped.
        if (r_react_pulse) begin
          w_state_nxt = SHOW;
        end else if (w_tick) begin
          if (w_at_max) begin
            w_state_nxt   = SHOW;
            w_set_timeout = 1'b1;
          end else begin
            w_cnt_en = 1'b1;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_lfsr    <= LFSR_SEED;
      r_presc   <= '0;
      r_dly     <= 16'd0;
      r_led_go  <= 1'b0;
      r_busy    <= 1'b0;
      r_early   <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_lfsr  <= lfsr_next(r_lfsr);

      if (w_state_nxt != r_state || w_tick) r_presc <= '0;
      else                                  r_presc <= r_presc + PW'(1);

      if (w_dly_load)     r_dly <= 16'(MIN_DLY_MS) + {5'd0, r_lfsr[10:0]};
      else if (w_dly_dec) r_dly <= r_dly - 16'd1;

      r_led_go <= (w_state_nxt == GO);
      r_busy   <= (w_state_nxt == WAIT) || (w_state_nxt == GO);
      r_early  <= (w_state_nxt == EARLY);

      if (w_dly_load)         r_timeout <= 1'b0;
      else if (w_set_timeout) r_timeout <= 1'b1;
    end
  end

  react_bcd_cnt u_bcd (
    .clk      (clk),
    .rst      (rst),
    .i_clr    (w_cnt_clr),
    .i_en     (w_cnt_en),
    .o_dat    (w_bcd),
    .o_at_max (w_at_max)
  );

endmodule

// File: doc/react_timer.md
Name: react_timer

Overview:
- Measurement core of the reaction tester. It produces the 16-bit, 4-digit BCD value that the seven-segment display driver consumes.
- Sequence: start press → pseudo-random delay → stimulus LED on → millisecond BCD count until the react press → result held for display.
- Detects an early press, shown as "EEEE", and a timeout, which saturates at 9999 ms.

Parameters:
- TICK_DIV, 100000: clk cycles per 1 ms tick (100 MHz board clock).
- MIN_DLY_MS, 1000: minimum random delay in ms.
- LFSR_SEED, 16'hACE1: reset value of the delay LFSR; must be nonzero.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset.
- btn_start  in  1  start button, asynchronous, clean level (already debounced), active-high.
- btn_react  in  1  reaction button, asynchronous, clean level, active-high.
- led_go  out  1  stimulus LED, high while counting.
- dat  out  16  4-digit BCD result: dat[15:12] is thousands, dat[3:0] is units.
- busy  out  1  high in WAIT or GO.
- early  out  1  latched flag: react pressed before stimulus.
- timeout  out  1  latched flag: count reached 9999 without a react press.

Behaviour:
- Reset rst, asynchronous, active-high; clock clk. All state updates on posedge clk.
- Reset values: state=IDLE, dat=16'h0000, led_go=0, busy=0, early=0, timeout=0, lfsr=LFSR_SEED, prescaler=0, delay counter=0.
- Input conditioning:
  - 2-FF synchronizer per button, then a rising-edge detect pulse, 1 clk wide.
  - Pin rise sampled at edge n gives its state effect visible after edge n+3.
  - Held buttons produce no further pulses.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11. Advances every clk in every state and never reaches zero.
- ms tick: prescaler counts 0..TICK_DIV-1; tick=1 on the cycle it equals TICK_DIV-1, then it wraps. Prescaler is cleared to 0 on every state entry.
- States:
  - IDLE, SHOW, EARLY: on start_pulse go to WAIT.
    - Load delay counter (12 bits+) = MIN_DLY_MS + lfsr[10:0].
    - Set dat=0, early=0, timeout=0.
    - All other inputs are ignored.
  - WAIT: busy=1, led_go=0. Delay counter decrements on each tick.
    - react_pulse goes to EARLY: dat=16'hEEEE, early=1. This has priority over a same-cycle delay expiry.
    - Tick while delay counter==1 goes to GO: led_go=1, dat=0.
  - GO: busy=1, led_go=1. On each tick dat does a BCD increment (digit 9 → 0 with carry into the next digit).
    - react_pulse goes to SHOW: led_go=0, dat frozen. A tick in the same cycle is discarded (react has priority).
    - Tick while dat==16'h9999 goes to SHOW: timeout=1, dat stays 16'h9999, led_go=0.
  - start_pulse in WAIT or GO is ignored (no restart).
- Output update:
  - dat changes only on those state-entry events and BCD increments; it is never a non-BCD value except 16'hEEEE.
  - busy, led_go, early and timeout are registered state decodes.
- Delay range: MIN_DLY_MS .. MIN_DLY_MS+2047 ms. Resolution: result within +0/−1 ms of the true delay from LED on to pin press, plus 3 clk sync latency.
- Reset mid-operation returns to IDLE with all outputs at their reset values on the same edge (asynchronous).

Decomposition:
- Shared package react_pkg:
  - State enum: IDLE, WAIT, GO, SHOW, EARLY.
  - DAT_EARLY=16'hEEEE, DAT_MAX=16'h9999.
  - LFSR tap constant.
- Sub-module react_bcd_cnt:
  - 4-digit BCD counter with synchronous clr, en (tick), and output at_max (==9999).
  - Saturates when en and at_max are both high.
  - The top level instantiates one react_bcd_cnt and holds the FSM, synchronizers, prescaler, LFSR and delay counter.

Test Plan (TICK_DIV=10, MIN_DLY_MS=2, LFSR_SEED=16'hACE1):
- Reset, then idle 100 clk → dat=0000, led_go=0, busy=0, early=0, timeout=0; react pulses while IDLE change nothing.
- Start pulse; wait for led_go rise; press react exactly 123 ticks (1230 clk) later → SHOW, led_go=0, dat=16'h0123 (±1 digit per the resolution rule), busy=0; dat stable thereafter.
- Start, then react pulse during WAIT before led_go → dat=16'hEEEE, early=1, led_go never rises; a subsequent start clears early and dat=0.
- Start, never press react → dat counts through 0009→0010, 0099→0100 and 0999→1000 correctly, reaching 16'h9999; next tick gives timeout=1, dat=9999, led_go=0.
- Start pulse during GO and during WAIT → ignored (delay and count continue); react on the exact tick cycle in GO → increment discarded, dat holds the pre-tick value.
- Assert rst mid-GO with dat=0456 → immediately dat=0, led_go=0, busy=0; after release, the first delay loaded equals MIN_DLY_MS + lfsr[10:0] predicted by a reference LFSR model.
